// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port FIFO: width math, modular pointer add,
// popcount and min.
package fifo_pkg;

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Compare-and-subtract wrap, so any DEPTH works; requires ptr < depth, inc <= depth.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_multiport_if.sv
// Multi-lane FIFO bus: per-lane write/read handshakes plus registered status.
interface fifo_multiport_if
    import fifo_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 16,
    parameter int NUM_WR  = 2,
    parameter int NUM_RD  = 2,
    parameter int MAX_CNT = 3
);
    localparam int CNT_W  = cnt_bits(DEPTH);
    localparam int SPOT_W = $clog2(MAX_CNT + 1);

    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][WIDTH-1:0]  wr_data;
    logic [NUM_WR-1:0]             wr_valid;
    logic [NUM_RD-1:0]             rd_en;
    logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]             rd_valid;
    logic [CNT_W-1:0]              count;
    logic [SPOT_W-1:0]             spots;
    logic                          full;
    logic                          empty;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_valid, rd_data, rd_valid, count, spots, full, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_valid, rd_data, rd_valid, count, spots, full, empty
    );

endinterface

// File: rtl/fifo_lane_grant.sv
// Grants the lowest-index set lanes of en, at most 'limit' of them, and
// reports each lane's rank among the granted lanes.
module fifo_lane_grant #(
    parameter int N  = 2,
    parameter int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         en,
    input  logic [31:0]          limit,
    output logic [N-1:0]         grant,
    output logic [N-1:0][RW-1:0] rank
);

    always_comb begin
        int unsigned taken;
        taken = 0;
        grant = '0;
        rank  = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = RW'(taken);
            if (en[i] && (taken < limit)) begin
                grant[i] = 1'b1;
                taken    = taken + 1;
            end
        end
    end

endmodule

// File: rtl/fifo_multiport.sv
// Multi-write / multi-read synchronous FIFO with strict lane-ascending order,
// same-cycle reuse of slots freed by reads, and no write-to-read bypass.
module fifo_multiport
    import fifo_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 16,
    parameter int NUM_WR  = 2,
    parameter int NUM_RD  = 2,
    parameter int MAX_CNT = 3
) (
    input logic              clock,
    input logic              reset,
    fifo_multiport_if.slave  bus
);

    localparam int CNT_W  = cnt_bits(DEPTH);
    localparam int PTR_W  = ptr_bits(DEPTH);
    localparam int SPOT_W = $clog2(MAX_CNT + 1);
    localparam int RRW    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WRW    = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [WIDTH-1:0]            mem_q [DEPTH];
    logic [WIDTH-1:0]            mem_d [DEPTH];
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic [NUM_RD-1:0]           rd_grant, rd_ok;
    logic [NUM_RD-1:0][RRW-1:0]  rd_rank;
    logic [NUM_WR-1:0]           wr_grant, wr_ok;
    logic [NUM_WR-1:0][WRW-1:0]  wr_rank;
    int unsigned                 rd_num, wr_num, wr_room, free_slots;

    fifo_lane_grant #(.N(NUM_RD), .RW(RRW)) u_rd_grant (
        .en    (bus.rd_en),
        .limit (32'(count_q)),
        .grant (rd_grant),
        .rank  (rd_rank)
    );

    // Slots vacated by this cycle's reads are offered to this cycle's writes.
    assign rd_num  = popcount(32'(rd_ok));
    assign wr_room = 32'(DEPTH) - 32'(count_q) + rd_num;

    fifo_lane_grant #(.N(NUM_WR), .RW(WRW)) u_wr_grant (
        .en    (bus.wr_en),
        .limit (wr_room),
        .grant (wr_grant),
        .rank  (wr_rank)
    );

    // Held in reset: no lane may report a grant.
    assign rd_ok  = rd_grant & {NUM_RD{reset}};
    assign wr_ok  = wr_grant & {NUM_WR{reset}};
    assign wr_num = popcount(32'(wr_ok));

    assign bus.rd_valid = rd_ok;
    assign bus.wr_valid = wr_ok;

    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            bus.rd_data[j] = mem_q[PTR_W'(ptr_add(32'(head_q), 32'(rd_rank[j]), DEPTH))];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_ok[i]) begin
                mem_d[PTR_W'(ptr_add(32'(tail_q), 32'(wr_rank[i]), DEPTH))] = bus.wr_data[i];
            end
        end
    end

    always_comb begin
        head_d  = PTR_W'(ptr_add(32'(head_q), rd_num, DEPTH));
        tail_d  = PTR_W'(ptr_add(32'(tail_q), wr_num, DEPTH));
        count_d = CNT_W'(32'(count_q) + wr_num - rd_num);
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign free_slots = 32'(DEPTH) - 32'(count_q);

    always_comb begin
        bus.count = count_q;
        bus.full  = (count_q == CNT_W'(DEPTH));
        bus.empty = (count_q == '0);
        bus.spots = SPOT_W'(umin(32'(MAX_CNT), free_slots));
    end

endmodule

// File: tb/tb_fifo_multiport.sv
// Randomized and directed checks of fifo_multiport against a queue model.
module tb_fifo_multiport;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 16;
    localparam int NUM_WR  = 2;
    localparam int NUM_RD  = 2;
    localparam int MAX_CNT = 3;

    logic clk;
    logic rst_n;

    fifo_multiport_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_WR(NUM_WR),
                        .NUM_RD(NUM_RD), .MAX_CNT(MAX_CNT)) bus ();

    fifo_multiport #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_WR(NUM_WR),
                     .NUM_RD(NUM_RD), .MAX_CNT(MAX_CNT)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int nvec = 0;
    int nerr = 0;

    logic [WIDTH-1:0]                we_q [$];
    logic [WIDTH-1:0]                q [$];
    logic [NUM_WR-1:0]               we_v;
    logic [NUM_RD-1:0]               re_v;
    logic [NUM_WR-1:0][WIDTH-1:0]    wd_v;
    int                              pend_r;
    logic [NUM_WR-1:0]               pend_wv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] re);
        we_v = we; re_v = re;
        wd_v[0] = d0; wd_v[1] = d1;
        bus.wr_en   = we_v;
        bus.wr_data = wd_v;
        bus.rd_en   = re_v;
    endtask

    // Expected grants from the queue: reads take the oldest entries, writes
    // fit into whatever room remains after those reads.
    task automatic model_check();
        int r, w, room;
        logic [1:0] rv, wv;
        r = 0; rv = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (re_v[j] && r < q.size()) begin
                rv[j] = 1'b1;
                chk("rd_data", 32'(bus.rd_data[j]), 32'(q[r]));
                r++;
            end
        end
        room = DEPTH - q.size() + r;
        w = 0; wv = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we_v[i] && w < room) begin
                wv[i] = 1'b1;
                w++;
            end
        end
        chk("rd_valid", 32'(bus.rd_valid), 32'(rv));
        chk("wr_valid", 32'(bus.wr_valid), 32'(wv));
        chk("count",    32'(bus.count),    32'(q.size()));
        chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(q.size() == 0));
        chk("spots",    32'(bus.spots),    32'((DEPTH - q.size() < MAX_CNT) ? DEPTH - q.size() : MAX_CNT));
        pend_r  = r;
        pend_wv = wv;
    endtask

    task automatic apply(input logic [1:0] we, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] re);
        drive(we, d0, d1, re);
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < pend_r; k++) void'(q.pop_front());
        for (int i = 0; i < NUM_WR; i++) if (pend_wv[i]) q.push_back(wd_v[i]);
        pend_r = 0; pend_wv = '0;
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            apply(2'b00, 16'h0, 16'h0, 2'b11);
            tick();
        end
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        pend_r = 0; pend_wv = '0;
        rst_n = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset mid-traffic
        apply(2'b11, 16'h0101, 16'h0102, 2'b00); tick();
        apply(2'b11, 16'h0103, 16'h0104, 2'b00); tick();
        apply(2'b01, 16'h0105, 16'h0000, 2'b00); tick();
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        drive(2'b11, 16'h0EEE, 16'h0FFF, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_spots",    32'(bus.spots),    32'd3);
        q.delete();
        drive(2'b00, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply(2'b01, 16'h00A0, 16'h0000, 2'b00); tick();
        apply(2'b00, 16'h0000, 16'h0000, 2'b01);
        chk("t1_readback", 32'(bus.rd_data[0]), 32'h00A0);
        tick();

        // 2: fill to full, then writes with no read are refused
        for (int k = 0; k < 4; k++) begin
            apply(2'b11, 16'(2 * k + 1), 16'(2 * k + 2), 2'b00);
            tick();
        end
        chk("t2_full", 32'(bus.full), 32'd1);
        chk("t2_spots", 32'(bus.spots), 32'd0);
        apply(2'b11, 16'h00AA, 16'h00BB, 2'b00);
        chk("t2_wr_refused", 32'(bus.wr_valid), 32'd0);
        tick();

        // 3: full read-out and refill in one cycle
        apply(2'b11, 16'd9, 16'd10, 2'b11);
        chk("t3_rd0", 32'(bus.rd_data[0]), 32'd1);
        chk("t3_rd1", 32'(bus.rd_data[1]), 32'd2);
        chk("t3_wv",  32'(bus.wr_valid),   32'd3);
        tick();
        chk("t3_count", 32'(bus.count), 32'd8);
        for (int k = 0; k < 4; k++) begin
            apply(2'b00, 16'h0, 16'h0, 2'b11);
            chk("t3_drain0", 32'(bus.rd_data[0]), 32'(2 * k + 3));
            chk("t3_drain1", 32'(bus.rd_data[1]), 32'(2 * k + 4));
            tick();
        end

        // 4: reads limited by occupancy, then none on empty
        apply(2'b01, 16'h0055, 16'h0000, 2'b00); tick();
        apply(2'b00, 16'h0000, 16'h0000, 2'b11);
        chk("t4_rv", 32'(bus.rd_valid), 32'd1);
        chk("t4_rd0", 32'(bus.rd_data[0]), 32'h0055);
        tick();
        chk("t4_count", 32'(bus.count), 32'd0);
        apply(2'b00, 16'h0000, 16'h0000, 2'b10);
        chk("t4_empty_rv", 32'(bus.rd_valid), 32'd0);
        tick();

        // 5: partial write grant at the space boundary
        for (int k = 0; k < 3; k++) begin
            apply(2'b11, 16'(16'h0060 + 2 * k), 16'(16'h0061 + 2 * k), 2'b00);
            tick();
        end
        apply(2'b01, 16'h0066, 16'h0000, 2'b00); tick();
        apply(2'b11, 16'h0071, 16'h0072, 2'b00);
        chk("t5_wv_partial", 32'(bus.wr_valid), 32'd1);
        tick();
        chk("t5_full", 32'(bus.full), 32'd1);
        apply(2'b00, 16'h0000, 16'h0000, 2'b01); tick();
        apply(2'b11, 16'h0081, 16'h0082, 2'b01);
        chk("t5_wv_both", 32'(bus.wr_valid), 32'd3);
        tick();
        drain();

        // 6: random traffic across the pointer wrap
        for (int k = 0; k < 20; k++) begin
            apply(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
